// File: rtl/lockstep_pkg.sv
// rtl/lockstep_pkg.sv - shared state type and bit-majority helper for the lockstep compare unit
package lockstep_pkg;

  typedef enum logic [1:0] {LS_DISABLED, LS_WARMUP, LS_CHECK, LS_FAULT} ls_state_e;

  localparam int unsigned LS_MAX_LANES = 32;

  // Majority over the low n bits; an exact tie resolves to tie.
  function automatic logic majority(input logic [LS_MAX_LANES-1:0] bits,
                                    input int unsigned n,
                                    input logic tie);
    int unsigned ones;
    ones = 0;
    for (int unsigned i = 0; i < LS_MAX_LANES; i++) begin
      if (i < n && bits[i]) ones++;
    end
    if (2 * ones > n) return 1'b1;
    else if (2 * ones == n) return tie;
    else return 1'b0;
  endfunction

endpackage

// File: rtl/lockstep_delay_line.sv
// rtl/lockstep_delay_line.sv - DELAY-stage skew line; MSB is a valid bit with async reset, DELAY=0 passes through
module lockstep_delay_line #(
  parameter int WIDTH = 65,
  parameter int DELAY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);

  if (DELAY == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign out_data = in_data;
  end else begin : g_regs
    logic [DELAY-1:0] vld;
    logic [WIDTH-2:0] dat [DELAY];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld <= '0;
      end else begin
        vld[0] <= in_data[WIDTH-1];
        for (int i = 1; i < DELAY; i++) vld[i] <= vld[i-1];
      end
    end

    // Payload is only meaningful alongside its valid bit, so it carries no reset.
    always_ff @(posedge clk) begin
      dat[0] <= in_data[WIDTH-2:0];
      for (int i = 1; i < DELAY; i++) dat[i] <= dat[i-1];
    end

    assign out_data = {vld[DELAY-1], dat[DELAY-1]};
  end

endmodule

// File: rtl/lockstep_compare_unit.sv
// rtl/lockstep_compare_unit.sv - lockstep checker comparing delayed lane 0 against shadow lanes; LOCKSTEP_VOTE_EN adds a majority voter
module lockstep_compare_unit
  import lockstep_pkg::*;
#(
  parameter int NUM_LANES = 3,
  parameter int WIDTH     = 64,
  parameter int DELAY     = 2,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_i,
  input  logic                       clr_i,
  input  logic [NUM_LANES-1:0]       valid_i,
  input  logic [NUM_LANES*WIDTH-1:0] lane_i,
  output logic                       mismatch_o,
  output logic                       fault_o,
  output logic                       irq_o,
  output logic [CNT_W-1:0]           mismatch_cnt_o,
  output logic [NUM_LANES-1:0]       first_mask_o,
  output logic [WIDTH-1:0]           voted_o
);

  localparam int WW = (DELAY > 1) ? $clog2(DELAY + 1) : 1;
  localparam logic [WW-1:0]    WARM_INIT = WW'(DELAY);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  ls_state_e            state, state_n;
  logic [WW-1:0]        warm, warm_n;
  logic [WIDTH:0]       d_in, d_out;
  logic                 v0d;
  logic [WIDTH-1:0]     data0d;
  logic [NUM_LANES-1:0] lane_mm;
  logic                 active, cmp;
  logic                 mm_q, irq_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_LANES-1:0] mask_q;
  logic [WIDTH-1:0]     voted_q, voted_d;

  assign d_in = {valid_i[0], lane_i[WIDTH-1:0]};

  lockstep_delay_line #(.WIDTH(WIDTH + 1), .DELAY(DELAY)) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (d_in),
    .out_data (d_out)
  );

  assign v0d    = d_out[WIDTH];
  assign data0d = d_out[WIDTH-1:0];

  always_comb begin
    lane_mm = '0;
    for (int k = 1; k < NUM_LANES; k++) begin
      lane_mm[k] = (v0d != valid_i[k]) || (v0d && (data0d != lane_i[k*WIDTH +: WIDTH]));
    end
  end

  // A clear in the same cycle suppresses the mismatch entirely.
  assign active = (state == LS_CHECK) || (state == LS_FAULT);
  assign cmp    = active && en_i && !clr_i && (|lane_mm);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LS_DISABLED;
      warm  <= '0;
    end else begin
      state <= state_n;
      warm  <= warm_n;
    end
  end

  always_comb begin
    state_n = state;
    warm_n  = warm;
    if (clr_i) begin
      state_n = en_i ? LS_WARMUP : LS_DISABLED;
      warm_n  = WARM_INIT;
    end else begin
      case (state)
        LS_DISABLED: begin
          if (en_i) begin
            state_n = LS_WARMUP;
            warm_n  = WARM_INIT;
          end
        end
        LS_WARMUP: begin
          if (!en_i) state_n = LS_DISABLED;
          else if (warm <= WW'(1)) state_n = LS_CHECK;
          else warm_n = warm - WW'(1);
        end
        LS_CHECK: begin
          if (!en_i) state_n = LS_DISABLED;
          else if (cmp) state_n = LS_FAULT;
        end
        LS_FAULT: state_n = LS_FAULT;
        default:  state_n = LS_DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_q    <= 1'b0;
      irq_q   <= 1'b0;
      cnt_q   <= '0;
      mask_q  <= '0;
      voted_q <= '0;
    end else begin
      mm_q    <= cmp;
      irq_q   <= (state_n == LS_FAULT);
      voted_q <= voted_d;
      if (clr_i) begin
        cnt_q  <= '0;
        mask_q <= '0;
      end else begin
        if (cmp && cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
        if (cmp && state == LS_CHECK) mask_q <= lane_mm;
      end
    end
  end

`ifdef LOCKSTEP_VOTE_EN
  if (NUM_LANES < 3 || NUM_LANES % 2 == 0 || NUM_LANES > LS_MAX_LANES) begin : g_bad_lanes
    $error("LOCKSTEP_VOTE_EN requires an odd NUM_LANES between 3 and 32");
  end

  // Invalid lanes vote as zero; ties go to the primary lane.
  always_comb begin : p_vote
    logic [LS_MAX_LANES-1:0] col;
    voted_d = '0;
    for (int b = 0; b < WIDTH; b++) begin
      col    = '0;
      col[0] = v0d & data0d[b];
      for (int k = 1; k < NUM_LANES; k++) col[k] = valid_i[k] & lane_i[k*WIDTH + b];
      voted_d[b] = majority(col, 32'(NUM_LANES), col[0]);
    end
  end
`else
  assign voted_d = v0d ? data0d : '0;
`endif

  assign mismatch_o     = mm_q;
  assign fault_o        = (state == LS_FAULT);
  assign irq_o          = irq_q;
  assign mismatch_cnt_o = cnt_q;
  assign first_mask_o   = mask_q;
  assign voted_o        = voted_q;

endmodule
